// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch path: NOP encoding,
// instruction type, boot/run state and PC-to-word-index helper.
package mips_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // sll r0,r0,0
    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [PC_W-3:0] word_index(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:2];
    endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Boot-load controller: BOOT/RUN state, load index, ready/loaded flags and
// the memory write strobe for the streaming loader port.
module inst_mem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IDX_W     = 10,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_valid,
    input  logic             i_load_last,
    output logic             o_load_ready,
    output logic             o_loaded,
    output logic             o_we,
    output logic [IDX_W-1:0] o_waddr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_load_idx;
    logic             r_ready;
    logic             r_loaded;
    logic             w_accept;

    assign w_accept = i_load_valid && r_ready;

    // BOOT/RUN sequencing; the final slot closes the image even without load_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (BOOT_LOAD) begin
                r_state <= BOOT;
            end else begin
                r_state <= RUN;
            end
            r_load_idx <= '0;
            r_ready    <= BOOT_LOAD;
            r_loaded   <= ~BOOT_LOAD;
        end else begin
            case (r_state)
                BOOT: begin
                    if (w_accept) begin
                        r_load_idx <= r_load_idx + IDX_W'(1);
                        if (i_load_last || (r_load_idx == LAST_IDX)) begin
                            r_state  <= RUN;
                            r_ready  <= 1'b0;
                            r_loaded <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_ready  <= 1'b0;
                    r_loaded <= 1'b1;
                end
                default: begin
                    r_state  <= RUN;
                    r_ready  <= 1'b0;
                    r_loaded <= 1'b1;
                end
            endcase
        end
    end

    assign o_load_ready = r_ready;
    assign o_loaded     = r_loaded;
    assign o_we         = w_accept;
    assign o_waddr      = r_load_idx;

endmodule

// File: rtl/inst_mem_pipe.sv
// Synchronous-read instruction memory with boot-load port and a registered
// IF/ID fetch output supporting stall, flush and PC fault flagging.
module inst_mem_pipe
    import mips_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] NOP       = DATA_W'(NOP_WORD),
    parameter bit                BOOT_LOAD = 1'b1,
    parameter string             INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              loaded,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fault
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              r_fault;

    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [PC_W-3:0]   w_index;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_misaligned;
    logic              w_range_err;

    inst_mem_loader #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .BOOT_LOAD (BOOT_LOAD)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_valid (load_valid),
        .i_load_last  (load_last),
        .o_load_ready (load_ready),
        .o_loaded     (loaded),
        .o_we         (w_we),
        .o_waddr      (w_waddr)
    );

    assign w_index      = word_index(PC_W'(pc));
    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_range_err  = (PC_W'(w_index) >= PC_W'(DEPTH));
    // Only used when the index is in range, so truncation is safe
    assign w_rd_idx     = w_index[IDX_W-1:0];

    // Boot image write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= load_data;
        end
    end

    // IF/ID output register: flush > stall > faulting fetch > fetch > bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else if (!loaded) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else if (flush) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else if (stall) begin
            r_inst       <= r_inst;
            r_inst_valid <= r_inst_valid;
            r_fault      <= r_fault;
        end else if (fetch_en && (w_misaligned || w_range_err)) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b1;
        end else if (fetch_en) begin
            r_inst       <= r_mem[w_rd_idx];
            r_inst_valid <= 1'b1;
            r_fault      <= 1'b0;
        end else begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end
    end

    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign fault      = r_fault;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Self-checking bench for inst_mem_pipe: per-cycle reference model for a
// DEPTH=1024 instance plus directed checks on a DEPTH=4 overflow instance.
module tb_inst_mem_pipe;

    localparam logic [31:0] NOPW = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (DEPTH=1024)
    logic        rst_n, load_valid, load_ready, load_last, loaded;
    logic        fetch_en, stall, flush, inst_valid, fault;
    logic [31:0] load_data, pc, inst;

    // Small instance for the overflow guard
    logic        d4_rst_n, d4_load_valid, d4_load_ready, d4_load_last, d4_loaded;
    logic        d4_fetch_en, d4_stall, d4_flush, d4_inst_valid, d4_fault;
    logic [31:0] d4_load_data, d4_pc, d4_inst;

    inst_mem_pipe #(.DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .loaded(loaded),
        .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc),
        .inst(inst), .inst_valid(inst_valid), .fault(fault)
    );

    inst_mem_pipe #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(d4_rst_n), .load_valid(d4_load_valid), .load_ready(d4_load_ready),
        .load_data(d4_load_data), .load_last(d4_load_last), .loaded(d4_loaded),
        .fetch_en(d4_fetch_en), .stall(d4_stall), .flush(d4_flush), .pc(d4_pc),
        .inst(d4_inst), .inst_valid(d4_inst_valid), .fault(d4_fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: image is an array, state is "loaded or not"
    logic [31:0] m_mem [1024];
    bit          m_loaded;
    int          m_idx;
    logic [31:0] e_inst;
    bit          e_valid, e_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loaded <= 1'b0; m_idx <= 0;
            e_inst <= NOPW; e_valid <= 1'b0; e_fault <= 1'b0;
        end else if (!m_loaded) begin
            e_inst <= NOPW; e_valid <= 1'b0; e_fault <= 1'b0;
            if (load_valid) begin
                m_mem[m_idx] <= load_data;
                m_idx        <= m_idx + 1;
                m_loaded     <= load_last || (m_idx == 1023);
            end
        end else if (flush) begin
            e_inst <= NOPW; e_valid <= 1'b0; e_fault <= 1'b0;
        end else if (stall) begin
            e_inst <= e_inst;
        end else if (fetch_en) begin
            if ((pc[1:0] != 2'b00) || ((pc / 4) >= 1024)) begin
                e_inst <= NOPW; e_valid <= 1'b0; e_fault <= 1'b1;
            end else begin
                e_inst <= m_mem[pc / 4]; e_valid <= 1'b1; e_fault <= 1'b0;
            end
        end else begin
            e_inst <= NOPW; e_valid <= 1'b0; e_fault <= 1'b0;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_inst",       inst,               e_inst);
            chk("model_inst_valid", 32'(inst_valid),    32'(e_valid));
            chk("model_fault",      32'(fault),         32'(e_fault));
            chk("model_loaded",     32'(loaded),        32'(m_loaded));
            chk("model_load_ready", 32'(load_ready),    32'(!m_loaded));
        end
    end

    task automatic load_beat(input logic [31:0] d, input bit last);
        load_valid = 1'b1; load_data = d; load_last = last;
        fetch_en = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom); pc = $urandom;
        @(negedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic cyc(input bit fe, input bit st, input bit fl, input logic [31:0] p);
        fetch_en = fe; stall = st; flush = fl; pc = p;
        @(negedge clk); #1;
    endtask

    logic [31:0] img [8];
    logic [31:0] old_w [3];
    logic [31:0] new_w [2];
    logic [31:0] v4 [6];
    logic [31:0] tmp;

    initial begin
        img[0] = 32'h2001_0028; img[1] = 32'h2002_0005; img[2] = 32'h0022_1820;
        img[3] = 32'h8C04_0000; img[4] = 32'hAC03_000C; img[5] = 32'h1000_0002;
        img[6] = 32'h0000_0000; img[7] = 32'hAC05_07D0;
        for (int i = 0; i < 3; i++) old_w[i] = $urandom;
        for (int i = 0; i < 2; i++) new_w[i] = $urandom;
        for (int i = 0; i < 6; i++) v4[i] = $urandom;

        rst_n = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; pc = 32'h0;
        d4_rst_n = 1'b0; d4_load_valid = 1'b0; d4_load_last = 1'b0; d4_load_data = 32'h0;
        d4_fetch_en = 1'b0; d4_stall = 1'b0; d4_flush = 1'b0; d4_pc = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_loaded", 32'(loaded), 32'h0);
        chk("rst_load_ready", 32'(load_ready), 32'h1);
        chk("rst_inst", inst, NOPW);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        #1 rst_n = 1'b1; d4_rst_n = 1'b1; cmp_en = 1'b1;

        // Reset part-way through a load, then a short image
        for (int i = 0; i < 3; i++) load_beat(old_w[i], 1'b0);
        rst_n = 1'b0; #1;
        chk("midrst_loaded", 32'(loaded), 32'h0);
        chk("midrst_load_ready", 32'(load_ready), 32'h1);
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        load_beat(new_w[0], 1'b0);
        load_beat(new_w[1], 1'b1);
        chk("midrst_reloaded", 32'(loaded), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);  chk("midrst_mem0", inst, new_w[0]);
        cyc(1'b1, 1'b0, 1'b0, 32'h4);  chk("midrst_mem1", inst, new_w[1]);
        cyc(1'b1, 1'b0, 1'b0, 32'h8);  chk("midrst_mem2_kept", inst, old_w[2]);

        // Full 8-word boot image
        rst_n = 1'b0; #1;
        chk("rst2_inst_valid", 32'(inst_valid), 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_beat(img[i], i == 7);
            if (i == 6) chk("boot_not_loaded_yet", 32'(loaded), 32'h0);
        end
        chk("boot_loaded", 32'(loaded), 32'h1);
        chk("boot_ready_low", 32'(load_ready), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("fetch_pc0", inst, 32'h2001_0028);
        chk("fetch_pc0_valid", 32'(inst_valid), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h1C); chk("fetch_pc1c", inst, 32'hAC05_07D0);

        // Back-to-back fetches
        cyc(1'b1, 1'b0, 1'b0, 32'h0);  chk("pipe_0", inst, img[0]);
        cyc(1'b1, 1'b0, 1'b0, 32'h4);  chk("pipe_1", inst, img[1]);
        cyc(1'b1, 1'b0, 1'b0, 32'h8);  chk("pipe_2", inst, img[2]);

        // Stall holds, flush beats stall
        cyc(1'b1, 1'b0, 1'b0, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h8);
            chk("stall_inst", inst, 32'h2002_0005);
            chk("stall_valid", 32'(inst_valid), 32'h1);
        end
        cyc(1'b1, 1'b1, 1'b1, 32'h8);
        chk("flush_inst", inst, NOPW);
        chk("flush_valid", 32'(inst_valid), 32'h0);

        // Faults
        cyc(1'b1, 1'b0, 1'b0, 32'h2);
        chk("misalign_inst", inst, NOPW);
        chk("misalign_valid", 32'(inst_valid), 32'h0);
        chk("misalign_fault", 32'(fault), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h1000); chk("range_fault", 32'(fault), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h8);
        chk("legal_fault_clear", 32'(fault), 32'h0);
        chk("legal_inst", inst, 32'h0022_1820);

        // Randomised traffic checked by the model
        for (int n = 0; n < 400; n++) begin
            load_valid = 1'($urandom); load_data = $urandom; load_last = 1'($urandom);
            fetch_en = ($urandom_range(0, 99) < 75);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 9))
                0: pc = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(1, 3));
                1: begin tmp = $urandom_range(1024, 32'h3FFF_FFFF); pc = tmp << 2; end
                default: pc = 32'($urandom_range(0, 7) * 4);
            endcase
            @(negedge clk); #1;
        end
        load_valid = 1'b0;

        // Overflow guard on the DEPTH=4 instance
        for (int b = 0; b < 6; b++) begin
            d4_load_valid = 1'b1; d4_load_data = v4[b];
            chk("ovf_ready", 32'(d4_load_ready), (b < 4) ? 32'h1 : 32'h0);
            @(negedge clk); #1;
        end
        d4_load_valid = 1'b0;
        chk("ovf_loaded", 32'(d4_loaded), 32'h1);
        for (int i = 0; i < 4; i++) begin
            d4_fetch_en = 1'b1; d4_pc = 32'(i * 4);
            @(negedge clk); #1;
            chk("ovf_mem", d4_inst, v4[i]);
            chk("ovf_valid", 32'(d4_inst_valid), 32'h1);
        end
        d4_pc = 32'h10; @(negedge clk); #1;
        chk("ovf_range_fault", 32'(d4_fault), 32'h1);
        chk("ovf_range_inst", d4_inst, NOPW);
        d4_pc = 32'hE; @(negedge clk); #1;
        chk("ovf_misalign_fault", 32'(d4_fault), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
